// File: rtl/traffic_light_pkg.sv
// Shared traffic-light phase codes, default dwell lengths and the legal phase order.
// Pure definitions; no timing and no flow control.
package traffic_light_pkg;

  localparam logic [1:0] PH_NONE   = 2'b00;
  localparam logic [1:0] PH_GREEN  = 2'b01;
  localparam logic [1:0] PH_RED    = 2'b10;
  localparam logic [1:0] PH_YELLOW = 2'b11;

  localparam int DEF_GREEN_LEN  = 5;
  localparam int DEF_YELLOW_LEN = 2;
  localparam int DEF_RED_LEN    = 3;

  // State codes equal the phase codes, so the state register drives the phase output directly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GREEN  = 2'b01,
    ST_RED    = 2'b10,
    ST_YELLOW = 2'b11
  } state_e;

  function automatic logic legal_step(input state_e from_st, input state_e to_st);
    return ((from_st == ST_GREEN)  && (to_st == ST_YELLOW)) ||
           ((from_st == ST_YELLOW) && (to_st == ST_RED))    ||
           ((from_st == ST_RED)    && (to_st == ST_GREEN));
  endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// Combinational decode of the three light lines into a phase code plus a valid bit.
// Zero latency; passive, no backpressure.
module traffic_light_decode
  import traffic_light_pkg::*;
(
  input  logic       i_green,
  input  logic       i_yellow,
  input  logic       i_red,
  output logic [1:0] o_phase,
  output logic       o_valid
);

  always_comb begin
    o_phase = PH_NONE;
    o_valid = 1'b0;
    case ({i_green, i_yellow, i_red})
      3'b100: begin o_phase = PH_GREEN;  o_valid = 1'b1; end
      3'b010: begin o_phase = PH_YELLOW; o_valid = 1'b1; end
      3'b001: begin o_phase = PH_RED;    o_valid = 1'b1; end
      default: begin o_phase = PH_NONE;  o_valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the traffic-light lines: phase decode, dwell timing, order/length errors, clean-lap count.
// Latency 1 cycle (all outputs registered); observe-only, no backpressure.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int GREEN_LEN  = DEF_GREEN_LEN,
  parameter int YELLOW_LEN = DEF_YELLOW_LEN,
  parameter int RED_LEN    = DEF_RED_LEN
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       green_light,
  input  logic       yellow_light,
  input  logic       red_light,
  input  logic       err_clr,
  output logic [1:0] phase,
  output logic [3:0] dwell,
  output logic       err_onehot,
  output logic       err_seq,
  output logic       err_len,
  output logic       err_any,
  output logic       cycle_done,
  output logic [7:0] laps_ok
);

  localparam logic [3:0] LEN_G = 4'(GREEN_LEN);
  localparam logic [3:0] LEN_Y = 4'(YELLOW_LEN);
  localparam logic [3:0] LEN_R = 4'(RED_LEN);

  logic [1:0] w_code;
  logic       w_valid;
  state_e     w_sample;
  logic [3:0] w_len;

  state_e     r_state,      w_state_nxt;
  logic [3:0] r_dwell,      w_dwell_nxt;
  logic       r_partial,    w_partial_nxt;
  logic       r_long,       w_long_nxt;
  logic       r_lap_clean,  w_lap_clean_nxt;
  logic       r_err_onehot, w_err_onehot_nxt;
  logic       r_err_seq,    w_err_seq_nxt;
  logic       r_err_len,    w_err_len_nxt;
  logic       r_err_any,    w_err_any_nxt;
  logic       r_cycle_done, w_cycle_done_nxt;
  logic [7:0] r_laps_ok,    w_laps_ok_nxt;

  traffic_light_decode u_decode (
    .i_green  (green_light),
    .i_yellow (yellow_light),
    .i_red    (red_light),
    .o_phase  (w_code),
    .o_valid  (w_valid)
  );

  assign w_sample = state_e'(w_code);

  always_comb begin
    w_len = 4'd0;
    case (r_state)
      ST_GREEN:  w_len = LEN_G;
      ST_YELLOW: w_len = LEN_Y;
      ST_RED:    w_len = LEN_R;
      default:   w_len = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dwell      <= 4'd0;
      r_partial    <= 1'b0;
      r_long       <= 1'b0;
      r_lap_clean  <= 1'b0;
      r_err_onehot <= 1'b0;
      r_err_seq    <= 1'b0;
      r_err_len    <= 1'b0;
      r_err_any    <= 1'b0;
      r_cycle_done <= 1'b0;
      r_laps_ok    <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_dwell      <= w_dwell_nxt;
      r_partial    <= w_partial_nxt;
      r_long       <= w_long_nxt;
      r_lap_clean  <= w_lap_clean_nxt;
      r_err_onehot <= w_err_onehot_nxt;
      r_err_seq    <= w_err_seq_nxt;
      r_err_len    <= w_err_len_nxt;
      r_err_any    <= w_err_any_nxt;
      r_cycle_done <= w_cycle_done_nxt;
      r_laps_ok    <= w_laps_ok_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_dwell_nxt      = r_dwell;
    w_partial_nxt    = r_partial;
    w_long_nxt       = r_long;
    w_lap_clean_nxt  = r_lap_clean;
    w_err_onehot_nxt = 1'b0;
    w_err_seq_nxt    = 1'b0;
    w_err_len_nxt    = 1'b0;
    w_cycle_done_nxt = 1'b0;
    w_laps_ok_nxt    = r_laps_ok;

    if (!w_valid) begin
      w_err_onehot_nxt = 1'b1;
      w_state_nxt      = ST_IDLE;
      w_dwell_nxt      = 4'd0;
      w_partial_nxt    = 1'b0;
      w_long_nxt       = 1'b0;
      w_lap_clean_nxt  = 1'b0;
    end else if (r_state == ST_IDLE) begin
      // Resync: the first phase is entered mid-way, so its exit length is not trusted.
      w_state_nxt     = w_sample;
      w_dwell_nxt     = 4'd1;
      w_partial_nxt   = 1'b1;
      w_long_nxt      = 1'b0;
      w_lap_clean_nxt = 1'b0;
    end else if (w_sample == r_state) begin
      if (r_dwell != 4'hF) w_dwell_nxt = r_dwell + 4'd1;
      if (!r_long && (r_dwell == w_len)) begin
        w_err_len_nxt = 1'b1;
        w_long_nxt    = 1'b1;
      end
    end else begin
      w_err_seq_nxt = !legal_step(r_state, w_sample);
      w_err_len_nxt = !r_partial && !r_long && (r_dwell < w_len);
      if ((r_state == ST_RED) && (w_sample == ST_GREEN)) begin
        if (r_lap_clean && !w_err_len_nxt) begin
          w_cycle_done_nxt = 1'b1;
          if (r_laps_ok != 8'hFF) w_laps_ok_nxt = r_laps_ok + 8'd1;
        end
        w_lap_clean_nxt = 1'b1;
      end
      w_state_nxt   = w_sample;
      w_dwell_nxt   = 4'd1;
      w_partial_nxt = 1'b0;
      w_long_nxt    = 1'b0;
    end

    if (w_err_onehot_nxt || w_err_seq_nxt || w_err_len_nxt) w_lap_clean_nxt = 1'b0;

    // A fresh error outranks a clear arriving on the same sample.
    w_err_any_nxt = (r_err_any && !err_clr) || w_err_onehot_nxt || w_err_seq_nxt || w_err_len_nxt;
  end

  assign phase      = r_state;
  assign dwell      = r_dwell;
  assign err_onehot = r_err_onehot;
  assign err_seq    = r_err_seq;
  assign err_len    = r_err_len;
  assign err_any    = r_err_any;
  assign cycle_done = r_cycle_done;
  assign laps_ok    = r_laps_ok;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with an expectation queue fed at drive time.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       green_light, yellow_light, red_light, err_clr;
  logic [1:0] phase;
  logic [3:0] dwell;
  logic       err_onehot, err_seq, err_len, err_any, cycle_done;
  logic [7:0] laps_ok;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .green_light  (green_light),
    .yellow_light (yellow_light),
    .red_light    (red_light),
    .err_clr      (err_clr),
    .phase        (phase),
    .dwell        (dwell),
    .err_onehot   (err_onehot),
    .err_seq      (err_seq),
    .err_len      (err_len),
    .err_any      (err_any),
    .cycle_done   (cycle_done),
    .laps_ok      (laps_ok)
  );

  typedef struct packed {
    logic [1:0] ph;
    logic [3:0] dw;
    logic       oh;
    logic       sq;
    logic       ln;
    logic       any;
    logic       done;
    logic [7:0] laps;
  } obs_t;

  obs_t exp_q[$];

  // Reference state of the checker as the bench understands the protocol.
  logic [1:0] m_ph;
  int         m_dw;
  bit         m_part, m_long, m_lap, m_any;
  int         m_laps;

  int n_done, n_len, n_seq, n_oh, idx, first_done;

  localparam bit [2:0] G = 3'b100;
  localparam bit [2:0] Y = 3'b010;
  localparam bit [2:0] R = 3'b001;
  localparam bit [2:0] GR = 3'b101;

  function automatic int req_len(logic [1:0] p);
    case (p)
      2'b01:   return 5;
      2'b11:   return 2;
      2'b10:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o = {phase, dwell, err_onehot, err_seq, err_len, err_any, cycle_done, laps_ok};
    return o;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ph = 2'b00; m_dw = 0; m_part = 0; m_long = 0; m_lap = 0; m_any = 0; m_laps = 0;
  endtask

  task automatic step(bit [2:0] lights, bit clr);
    obs_t e, o;
    bit v, oh, sq, ln, dn;
    logic [1:0] c;
    oh = 0; sq = 0; ln = 0; dn = 0;
    {green_light, yellow_light, red_light} = lights;
    err_clr = clr;

    v = (lights == G) || (lights == Y) || (lights == R);
    c = (lights == G) ? 2'b01 : (lights == R) ? 2'b10 : 2'b11;
    if (!v) begin
      oh = 1; m_ph = 2'b00; m_dw = 0; m_lap = 0;
    end else if (m_ph == 2'b00) begin
      m_ph = c; m_dw = 1; m_part = 1; m_long = 0; m_lap = 0;
    end else if (c == m_ph) begin
      if (m_dw < 15) m_dw++;
      if (!m_long && m_dw == req_len(m_ph) + 1) begin ln = 1; m_long = 1; end
    end else begin
      sq = !((m_ph == 2'b01 && c == 2'b11) || (m_ph == 2'b11 && c == 2'b10) ||
             (m_ph == 2'b10 && c == 2'b01));
      ln = !m_part && !m_long && (m_dw < req_len(m_ph));
      if (m_ph == 2'b10 && c == 2'b01) begin
        if (m_lap && !ln) begin dn = 1; if (m_laps < 255) m_laps++; end
        m_lap = 1;
      end
      m_ph = c; m_dw = 1; m_part = 0; m_long = 0;
    end
    if (oh || sq || ln) m_lap = 0;
    m_any = (m_any && !clr) || oh || sq || ln;

    e.ph = m_ph; e.dw = 4'(m_dw); e.oh = oh; e.sq = sq; e.ln = ln;
    e.any = m_any; e.done = dn; e.laps = 8'(m_laps);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    o = cur_obs();
    e = exp_q.pop_front();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL sb[%0d]: observed=%h expected=%h", idx, o, e);
    end
    n_done += int'(cycle_done);
    n_len  += int'(err_len);
    n_seq  += int'(err_seq);
    n_oh   += int'(err_onehot);
    if (cycle_done && first_done < 0) first_done = idx;
    idx++;
  endtask

  task automatic run(bit [2:0] lights, int n);
    for (int i = 0; i < n; i++) step(lights, 1'b0);
  endtask

  task automatic lap();
    run(G, 5); run(Y, 2); run(R, 3);
  endtask

  initial begin
    reset = 1'b1;
    {green_light, yellow_light, red_light} = 3'b000;
    err_clr = 1'b0;
    model_reset();
    n_done = 0; n_len = 0; n_seq = 0; n_oh = 0; idx = 0; first_done = -1;
    #12;
    chk("reset_outputs", 32'(cur_obs()), 32'd0);
    reset = 1'b0;

    // Correct controller: samples 0..50 following G5 Y2 R3 from reset.
    for (int i = 0; i < 51; i++) begin
      if (i % 10 < 5)      step(G, 1'b0);
      else if (i % 10 < 7) step(Y, 1'b0);
      else                 step(R, 1'b0);
    end
    chk("first_done_idx", 32'(first_done), 32'd20);
    chk("done_count", 32'(n_done), 32'd4);
    chk("laps_ok_50", 32'(laps_ok), 32'd4);
    chk("clean_errs", 32'(n_len + n_seq + n_oh), 32'd0);
    chk("clean_any", 32'(err_any), 32'd0);

    // Green held 7 samples: last sample was green #1.
    for (int k = 2; k <= 7; k++) begin
      step(G, 1'b0);
      chk($sformatf("green_long_%0d", k), 32'(err_len), 32'(k == 6));
    end
    run(Y, 2); run(R, 3); step(G, 1'b0);
    chk("long_lap_done", 32'(cycle_done), 32'd0);
    chk("long_lap_laps", 32'(laps_ok), 32'd4);

    // Short yellow.
    run(G, 4); step(Y, 1'b0); step(R, 1'b0);
    chk("short_y_len", 32'(err_len), 32'd1);
    chk("short_y_any", 32'(err_any), 32'd1);
    run(R, 2); step(G, 1'b0);
    chk("short_y_done", 32'(cycle_done), 32'd0);

    // Clear without a competing error.
    step(G, 1'b1);
    chk("clr_any", 32'(err_any), 32'd0);

    // Direct G->R: order error plus short green.
    step(R, 1'b0);
    chk("gr_seq", 32'(err_seq), 32'd1);
    chk("gr_len", 32'(err_len), 32'd1);
    chk("gr_phase", 32'(phase), 32'd2);
    chk("gr_dwell", 32'(dwell), 32'd1);

    // Two lights with a clear on the same sample: set wins.
    step(GR, 1'b1);
    chk("gr2_onehot", 32'(err_onehot), 32'd1);
    chk("gr2_phase", 32'(phase), 32'd0);
    chk("gr2_any", 32'(err_any), 32'd1);

    // Resync on a short green that must not be length-checked.
    step(G, 1'b0);
    chk("resync_phase", 32'(phase), 32'd1);
    chk("resync_dwell", 32'(dwell), 32'd1);
    step(G, 1'b0); step(Y, 1'b0);
    chk("resync_len", 32'(err_len), 32'd0);
    chk("resync_seq", 32'(err_seq), 32'd0);
    step(Y, 1'b0); run(R, 2);

    // Asynchronous reset in the middle of red.
    #2 reset = 1'b1;
    #1;
    chk("midred_outputs", 32'(cur_obs()), 32'd0);
    chk("midred_laps", 32'(laps_ok), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;

    // Long red saturates dwell and flags once; then the counter saturates.
    run(G, 5); run(Y, 2);
    n_len = 0;
    run(R, 17);
    chk("red_sat_dwell", 32'(dwell), 32'd15);
    chk("red_sat_len", 32'(n_len), 32'd1);
    run(Y, 2); run(R, 3);
    for (int l = 0; l < 258; l++) lap();
    step(G, 1'b0);
    chk("laps_sat", 32'(laps_ok), 32'd255);
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker at the receiving end of the traffic-light interface. It samples the `green_light`, `yellow_light` and `red_light` lines driven by the light controller and decodes them back into a phase. It measures how long each phase lasts and flags illegal encodings, illegal phase orders and wrong phase durations. It also counts clean G→Y→R laps. It sits beside the controller in the lab top level and in the bench as the scoreboard front end.

## Interface
- `GREEN_LEN`, 5, required green dwell in cycles (legal range 1..14)
- `YELLOW_LEN`, 2, required yellow dwell in cycles (legal range 1..14)
- `RED_LEN`, 3, required red dwell in cycles (legal range 1..14)
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `green_light`  in  1  observed green line
- `yellow_light`  in  1  observed yellow line
- `red_light`  in  1  observed red line
- `err_clr`  in  1  synchronous clear of `err_any`
- `phase`  out  2  current decoded phase: NONE=00, GREEN=01, RED=10, YELLOW=11
- `dwell`  out  4  cycles spent in the current phase, counting from 1; saturates at 15
- `err_onehot`  out  1  one-cycle pulse: sample was dark or had more than one light
- `err_seq`  out  1  one-cycle pulse: illegal phase transition
- `err_len`  out  1  one-cycle pulse: phase too short at exit, or too long
- `err_any`  out  1  sticky OR of all error pulses
- `cycle_done`  out  1  one-cycle pulse: a fully checked, clean lap completed
- `laps_ok`  out  8  count of clean laps; saturates at 255

## Operation
- Light decode:
  - exactly one line high → GREEN, YELLOW or RED
  - otherwise → invalid
- FSM states: IDLE, GREEN, YELLOW, RED. Reset puts the FSM in IDLE.
- **IDLE.** A valid sample moves the FSM to the matching phase with `dwell`=1 and `partial`=1. The first phase after sync is not length-checked at exit.
- **Phase state, same light sampled.**
  - `dwell` increments, saturating at 15.
  - When `dwell` would reach LEN+1, `err_len` pulses once. The internal `long_flagged` bit is set, so the phase is not flagged again.
- **Phase state, different valid light sampled.**
  - Legal order is G→Y, Y→R, R→G. Any other change pulses `err_seq`.
  - If the phase being exited has `partial`=0, `long_flagged`=0 and `dwell`<LEN, `err_len` pulses.
  - The FSM enters the new phase with `dwell`=1, and clears `partial` and `long_flagged`.
- **Invalid sample in any state.**
  - `err_onehot` pulses.
  - The FSM goes to IDLE, `dwell` becomes 0 and `phase` becomes NONE.
  - The lap tracker is reset. Resync follows the IDLE rule.
- **Lap tracker.**
  - Per-lap bit `lap_clean` is set on entering GREEN from RED.
  - It is cleared by any error, and by an unchecked (partial) phase inside the lap.
  - On a legal R→G change with `lap_clean`=1 and the red length OK, `cycle_done` pulses and `laps_ok` increments (saturating).
- **`err_any`.**
  - Set by any error pulse.
  - Cleared by `err_clr`, unless an error pulses in the same cycle; set wins.
- Simultaneous `err_seq` and `err_len` on one sample: both pulse.

## Timing
- Lights are sampled on each rising edge. All outputs are registered. A response appears in the cycle right after the sampling edge (latency 1).
- On reset, all outputs are 0: `phase`=NONE, `dwell`=0, all errors 0, `cycle_done`=0, `laps_ok`=0.
- Reset asserted mid-lap: everything returns to reset values immediately, with no pulse emitted.
- Pulses are exactly one cycle wide. Back-to-back pulses on consecutive samples are allowed.
- With a correct controller (10-cycle lap: G5, Y2, R3):
  - `cycle_done` fires once every 10 cycles.
  - No `cycle_done` fires for the first lap, because its green is partial.

## Structure
- Shared package `traffic_light_pkg`:
  - phase encoding constants NONE/GREEN/RED/YELLOW (00/01/10/11), the same codes the controller uses
  - default lengths 5/2/3
- Natural sub-module: `traffic_light_decode`, a combinational decode of the three lines to a phase code plus a valid bit. The FSM, dwell counter, error logic and lap counter live in the top module.

## Test plan
- Drive from a correct controller, 50 cycles after reset:
  - first `cycle_done` at end of lap 2
  - then one pulse every 10 cycles
  - `laps_ok`=4
  - all errors 0
- Green held 7 cycles: `err_len` pulses exactly once, on the 6th green sample. The lap is not counted.
- Yellow held 1 cycle then red: `err_len` pulses at the Y→R sample. `err_any`=1.
- Direct G→R: `err_seq` pulses. `phase`=RED with `dwell`=1 the next cycle.
- Sample with green and red both high: `err_onehot` pulses and `phase`=NONE. On the next valid green the FSM resyncs and that green is not length-checked.
- `err_clr` with no error: `err_any` drops to 0. `err_clr` with an error in the same cycle: `err_any` stays 1.
- Reset asserted mid-red: all outputs 0 in the same cycle and `laps_ok`=0.
